tour_seq: RTL

Parametrised tour command sequencer: replays a precomputed knight's tour of `TOUR_LEN` moves as a stream of vertical and horizontal movement commands to `cmd_proc`. It sits between `UART_wrapper`/`TourLogic` and `cmd_proc`. While a tour is running it takes over the command path. It adds four things:
- abort via a UART opcode
- a per-leg timeout
- one-hot move checking
- selectable fanfare

---
 rtl/tour_pkg.sv | 57 +++++
 rtl/leg_timer.sv | 27 ++
 rtl/tour_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
// tour_pkg: state encoding, command field constants and knight-move decoding
// shared by the tour command sequencer.
package tour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VERT      = 3'd1,
        ST_VERT_WAIT = 3'd2,
        ST_HORZ      = 3'd3,
        ST_HORZ_WAIT = 3'd4,
        ST_ERR       = 3'd5
    } tour_state_t;

    localparam logic [3:0] OPC_MOVE    = 4'h2;
    localparam logic [3:0] OPC_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef struct packed {
        logic       legal;
        logic [7:0] vert_hdg;
        logic [3:0] vert_sq;
        logic [7:0] horz_hdg;
        logic [3:0] horz_sq;
    } move_dec_t;

    // Each knight move splits into a vertical leg followed by a horizontal leg.
    function automatic move_dec_t move_decode(input logic [7:0] move);
        move_dec_t d;
        d = '0;
        case (move)
            8'b0000_0001: d = '{legal: 1'b1, vert_hdg: HDG_N, vert_sq: 4'd2, horz_hdg: HDG_W, horz_sq: 4'd1};
            8'b0000_0010: d = '{legal: 1'b1, vert_hdg: HDG_N, vert_sq: 4'd2, horz_hdg: HDG_E, horz_sq: 4'd1};
            8'b0000_0100: d = '{legal: 1'b1, vert_hdg: HDG_N, vert_sq: 4'd1, horz_hdg: HDG_W, horz_sq: 4'd2};
            8'b0000_1000: d = '{legal: 1'b1, vert_hdg: HDG_S, vert_sq: 4'd1, horz_hdg: HDG_W, horz_sq: 4'd2};
            8'b0001_0000: d = '{legal: 1'b1, vert_hdg: HDG_S, vert_sq: 4'd2, horz_hdg: HDG_W, horz_sq: 4'd1};
            8'b0010_0000: d = '{legal: 1'b1, vert_hdg: HDG_S, vert_sq: 4'd2, horz_hdg: HDG_E, horz_sq: 4'd1};
            8'b0100_0000: d = '{legal: 1'b1, vert_hdg: HDG_S, vert_sq: 4'd1, horz_hdg: HDG_E, horz_sq: 4'd2};
            8'b1000_0000: d = '{legal: 1'b1, vert_hdg: HDG_N, vert_sq: 4'd1, horz_hdg: HDG_E, horz_sq: 4'd2};
            default:      d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [15:0] make_cmd(input logic [3:0] opc,
                                             input logic [7:0] hdg,
                                             input logic [3:0] sq);
        return {opc, hdg, sq};
    endfunction

endpackage

// File: rtl/leg_timer.sv
// leg_timer: per-leg cycle counter with a terminal-count flag; a TERMINAL of
// zero never fires.
module leg_timer #(
    parameter logic [31:0] TERMINAL = 32'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [31:0] count;

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

    // Fires on the cycle whose edge would bring the count to TERMINAL.
    assign tc = en && (TERMINAL != 32'd0) && (count == TERMINAL - 32'd1);

endmodule

// File: rtl/tour_seq.sv
// tour_seq: replays a knight's tour as vertical/horizontal commands to
// cmd_proc, owning the command path while busy; supports UART abort and timeout.
module tour_seq
    import tour_pkg::*;
#(
    parameter int          TOUR_LEN    = 24,
    parameter logic [31:0] LEG_TIMEOUT = 32'd50_000_000,
    parameter bit          FANFARE_ALL = 1'b1,
    parameter logic [3:0]  ABORT_OPC   = 4'hF,
    localparam int         IDX_W       = (TOUR_LEN > 1) ? $clog2(TOUR_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             uart_clr,
    output logic             tour_busy,
    output logic             tour_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOUR_LEN - 1);

    tour_state_t state, state_nxt;
    move_dec_t   dec;
    logic        busy;
    logic        last_leg;
    logic        abort_hit;
    logic        leg_state;
    logic        leg_clr;
    logic        timeout;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic [3:0]  horz_opc;
    logic [15:0] fsm_cmd;
    logic        fsm_rdy;

    assign dec       = move_decode(move);
    assign busy      = (state != ST_IDLE);
    assign last_leg  = (mv_indx == LAST_IDX);
    assign abort_hit = busy && cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OPC);
    assign leg_state = (state == ST_VERT) || (state == ST_VERT_WAIT) ||
                       (state == ST_HORZ) || (state == ST_HORZ_WAIT);
    assign leg_clr   = (state_nxt != state) || (state == ST_IDLE);

    leg_timer #(
        .TERMINAL (LEG_TIMEOUT)
    ) u_leg_timer (
        .clk (clk),
        .rst (rst),
        .clr (leg_clr),
        .en  (leg_state),
        .tc  (timeout)
    );

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start_tour) state_nxt = ST_VERT;
            ST_VERT: begin
                if (!dec.legal)       state_nxt = ST_ERR;
                else if (clr_cmd_rdy) state_nxt = ST_VERT_WAIT;
            end
            ST_VERT_WAIT: if (send_resp) state_nxt = ST_HORZ;
            ST_HORZ:      if (clr_cmd_rdy) state_nxt = ST_HORZ_WAIT;
            ST_HORZ_WAIT: if (send_resp) state_nxt = last_leg ? ST_IDLE : ST_VERT;
            ST_ERR:       state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (timeout) begin
            state_nxt = ST_ERR;
        end
        // Abort outranks timeout and illegal-move errors.
        if (abort_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mv_indx  <= '0;
            tour_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start_tour) begin
                mv_indx  <= '0;
                tour_err <= 1'b0;
            end else if (state == ST_HORZ_WAIT && state_nxt == ST_VERT) begin
                mv_indx <= mv_indx + IDX_W'(1);
            end
            if (state == ST_ERR && !abort_hit) begin
                tour_err <= 1'b1;
            end
        end
    end

    assign horz_opc = (FANFARE_ALL || last_leg) ? OPC_FANFARE : OPC_MOVE;
    assign vert_cmd = make_cmd(OPC_MOVE, dec.vert_hdg, dec.vert_sq);
    assign horz_cmd = make_cmd(horz_opc, dec.horz_hdg, dec.horz_sq);

    // An illegal move never raises cmd_rdy, so no bogus command reaches cmd_proc.
    always_comb begin
        fsm_cmd = '0;
        fsm_rdy = 1'b0;
        case (state)
            ST_VERT: begin
                fsm_cmd = vert_cmd;
                fsm_rdy = dec.legal;
            end
            ST_VERT_WAIT: fsm_cmd = vert_cmd;
            ST_HORZ: begin
                fsm_cmd = horz_cmd;
                fsm_rdy = 1'b1;
            end
            ST_HORZ_WAIT: fsm_cmd = horz_cmd;
            default: begin
                fsm_cmd = '0;
                fsm_rdy = 1'b0;
            end
        endcase
    end

    assign cmd       = busy ? fsm_cmd : cmd_UART;
    assign cmd_rdy   = busy ? fsm_rdy : cmd_rdy_UART;
    assign tour_busy = busy;
    assign uart_clr  = abort_hit && !rst;
    assign resp      = (state == ST_IDLE || (state == ST_HORZ_WAIT && last_leg)) ?
                       RESP_DONE : RESP_BUSY;

endmodule
